// File: rtl/muxer_regn_hold.sv
// ---------------------------------------------------------------------------
// muxer_regn_hold
//
// Registered N:1 signal router for the lock-in/PID signal chain. One of N_IN
// RES-bit channels is routed onto a registered output. A channel change is
// requested with a strobe. Before the new channel is routed, the output is
// frozen for a programmable settling interval, so downstream stages never
// see a splice in the middle of a cycle.
//
// Optional feature macro: MUXER_REGN_BLANK_EN
//   defined   -> out is driven to 0 (mid-scale for signed data) while a
//                switch is in progress
//   undefined -> out holds the last sample of the old channel while a switch
//                is in progress
//
// Parameters:
//   RES     sample width in bits
//   N_IN    number of input channels (2..64)
//   SELW    select width, 2**SELW >= N_IN
//   HOLD_W  width of the hold-interval register
//
// Ports:
//   clk          system clock
//   rstn         asynchronous active-low reset
//   in_bus       packed channels, channel k at [k*RES +: RES]
//   sel          requested channel index
//   sel_update   request strobe, sampled every cycle
//   hold_cycles  settling interval, sampled when a request is accepted
//   out          registered routed sample
//   out_sel      index of the channel currently driving out
//   busy         switch in progress, requests are ignored
//   done         one-cycle pulse when a switch completes
//   err          one-cycle pulse when an out-of-range request is rejected
// ---------------------------------------------------------------------------
module muxer_regn_hold #(
  parameter int RES    = 14,
  parameter int N_IN   = 16,
  parameter int SELW   = 6,
  parameter int HOLD_W = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [N_IN*RES-1:0]   in_bus,
  input  logic [SELW-1:0]       sel,
  input  logic                  sel_update,
  input  logic [HOLD_W-1:0]     hold_cycles,
  output logic [RES-1:0]        out,
  output logic [SELW-1:0]       out_sel,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    SWITCH
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [HOLD_W-1:0]   cnt;
  logic [HOLD_W-1:0]   cnt_next;
  logic [SELW-1:0]     pending;
  logic [SELW-1:0]     pending_next;
  logic [SELW-1:0]     out_sel_next;
  logic [RES-1:0]      out_next;
  logic                busy_next;
  logic                done_next;
  logic                err_next;

  logic [RES-1:0]      cur_sample;
  logic [RES-1:0]      frozen_sample;
  logic                sel_valid;

  // Sample of the channel currently selected for pass-through.
  assign cur_sample = in_bus[int'(out_sel)*RES +: RES];

  // Compare at 32 bits so that N_IN == 2**SELW cannot overflow the select width.
  assign sel_valid = (32'(sel) < 32'(N_IN));

  // Value presented on out while a switch is in flight.
`ifdef MUXER_REGN_BLANK_EN
  assign frozen_sample = '0;
`else
  assign frozen_sample = out;
`endif

  // Next-state and output logic. The accept edge itself already freezes the
  // output, so out never carries a sample taken after the request.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    pending_next = pending;
    out_sel_next = out_sel;
    out_next     = frozen_sample;
    busy_next    = busy;
    done_next    = 1'b0;
    err_next     = 1'b0;

    case (state)
      IDLE: begin
        out_next = cur_sample;
        if (sel_update) begin
          if (sel_valid) begin
            pending_next = sel;
            cnt_next     = hold_cycles;
            busy_next    = 1'b1;
            out_next     = frozen_sample;
            state_next   = (hold_cycles != '0) ? HOLD : SWITCH;
          end else begin
            err_next = 1'b1;
          end
        end
      end

      // cnt enters HOLD equal to H and moves on once it has counted down to 1,
      // so HOLD lasts exactly H cycles.
      HOLD: begin
        cnt_next = cnt - HOLD_W'(1);
        if (cnt <= HOLD_W'(1)) begin
          cnt_next   = '0;
          state_next = SWITCH;
        end
      end

      // The new select takes effect here. The output is still frozen on this
      // edge and tracks the new channel from the following edge onward.
      SWITCH: begin
        out_sel_next = pending;
        busy_next    = 1'b0;
        done_next    = 1'b1;
        state_next   = IDLE;
      end

      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  // State and output registers. An asynchronous reset drops any pending
  // request without reporting done.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      pending <= '0;
      out_sel <= '0;
      out     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      pending <= pending_next;
      out_sel <= out_sel_next;
      out     <= out_next;
      busy    <= busy_next;
      done    <= done_next;
      err     <= err_next;
    end
  end

endmodule

// File: tb/tb_muxer_regn_hold.sv
// ---------------------------------------------------------------------------
// tb_muxer_regn_hold
//
// Directed testbench for muxer_regn_hold with the default parameters
// (RES=14, N_IN=16, SELW=6, HOLD_W=8). Expected values are computed by hand
// from the channel table below. The expected frozen value follows
// MUXER_REGN_BLANK_EN.
// ---------------------------------------------------------------------------
module tb_muxer_regn_hold;

  localparam int RES    = 14;
  localparam int N_IN   = 16;
  localparam int SELW   = 6;
  localparam int HOLD_W = 8;

`ifdef MUXER_REGN_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic                 clk;
  logic                 rstn;
  logic [N_IN*RES-1:0]  in_bus;
  logic [SELW-1:0]      sel;
  logic                 sel_update;
  logic [HOLD_W-1:0]    hold_cycles;
  logic [RES-1:0]       out;
  logic [SELW-1:0]      out_sel;
  logic                 busy;
  logic                 done;
  logic                 err;

  int vectors;
  int miscompares;
  int expSel;
  logic [RES-1:0] chVal [N_IN];

  muxer_regn_hold #(
    .RES    (RES),
    .N_IN   (N_IN),
    .SELW   (SELW),
    .HOLD_W (HOLD_W)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_bus      (in_bus),
    .sel         (sel),
    .sel_update  (sel_update),
    .hold_cycles (hold_cycles),
    .out         (out),
    .out_sel     (out_sel),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge, where outputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point: counts every vector and reports any miscompare.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one complete switch from expSel to newSel with hold interval h and
  // checks every cycle from the accept edge t to edge t+h+2. When spam is
  // set, a sel=7 request stays asserted for the whole busy window, including
  // the cycle that re-enters IDLE. That request must be ignored.
  task automatic applyStimulus(input int newSel, input int h, input bit spam);
    logic [31:0] frozen;
    frozen = BLANK ? 32'd0 : 32'(chVal[expSel]);
    sel         = SELW'(newSel);
    hold_cycles = HOLD_W'(h);
    sel_update  = 1'b1;
    tick();                                  // edge t: accept
    hold_cycles = 8'd200;                    // must not affect the latched H
    if (spam) begin
      sel = 6'd7;
    end else begin
      sel_update = 1'b0;
      sel        = 6'd9;
    end
    checkOutput("acceptBusy", 32'(busy), 32'd1);
    checkOutput("acceptOut", 32'(out), frozen);
    checkOutput("acceptSel", 32'(out_sel), 32'(expSel));
    checkOutput("acceptDone", 32'(done), 32'd0);
    for (int i = 1; i <= h; i++) begin       // edges t+1 .. t+h
      tick();
      checkOutput("holdBusy", 32'(busy), 32'd1);
      checkOutput("holdOut", 32'(out), frozen);
      checkOutput("holdDone", 32'(done), 32'd0);
      checkOutput("holdSel", 32'(out_sel), 32'(expSel));
    end
    tick();                                  // edge t+h+1: back in IDLE
    sel_update = 1'b0;
    checkOutput("switchBusy", 32'(busy), 32'd0);
    checkOutput("switchDone", 32'(done), 32'd1);
    checkOutput("switchSel", 32'(out_sel), 32'(newSel));
    checkOutput("switchOut", 32'(out), frozen);
    expSel = newSel;
    tick();                                  // edge t+h+2: new channel visible
    checkOutput("newOut", 32'(out), 32'(chVal[newSel]));
    checkOutput("newDone", 32'(done), 32'd0);
    checkOutput("newBusy", 32'(busy), 32'd0);
    checkOutput("newSel", 32'(out_sel), 32'(newSel));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    expSel      = 0;
    for (int k = 0; k < N_IN; k++) chVal[k] = RES'(14'h0100 + k);
    chVal[0] = 14'h1234;
    chVal[1] = 14'h0111;
    chVal[3] = 14'h0ABC;
    chVal[5] = 14'h3F00;
    chVal[7] = 14'h0777;
    for (int k = 0; k < N_IN; k++) in_bus[k*RES +: RES] = chVal[k];
    sel         = '0;
    sel_update  = 1'b0;
    hold_cycles = '0;
    rstn        = 1'b0;

    // Reset values, also across a clock edge while reset is held
    #2;
    checkOutput("rstOut", 32'(out), 32'd0);
    checkOutput("rstSel", 32'(out_sel), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstErr", 32'(err), 32'd0);
    tick();
    checkOutput("rstOutHeld", 32'(out), 32'd0);
    #2 rstn = 1'b1;

    // Pass-through of channel 0 after one edge
    tick();
    checkOutput("passOut", 32'(out), 32'h1234);
    checkOutput("passBusy", 32'(busy), 32'd0);

    // Zero hold 0->1, then 1->3 with H=1, then 3->5 with H=4
    applyStimulus(1, 0, 1'b0);
    applyStimulus(3, 1, 1'b0);
    applyStimulus(5, 4, 1'b0);

    // Out-of-range requests: sel=20 and the boundary sel=N_IN
    sel = 6'd20; sel_update = 1'b1;
    tick();
    sel_update = 1'b0;
    checkOutput("oorErr", 32'(err), 32'd1);
    checkOutput("oorBusy", 32'(busy), 32'd0);
    checkOutput("oorSel", 32'(out_sel), 32'd5);
    checkOutput("oorOut", 32'(out), 32'h3F00);
    tick();
    checkOutput("oorErrEnd", 32'(err), 32'd0);
    sel = 6'd16; sel_update = 1'b1;
    tick();
    sel_update = 1'b0;
    checkOutput("edgeErr", 32'(err), 32'd1);
    checkOutput("edgeBusy", 32'(busy), 32'd0);
    tick();
    checkOutput("edgeErrEnd", 32'(err), 32'd0);
    checkOutput("edgeSel", 32'(out_sel), 32'd5);

    // Highest valid channel, then a same-channel re-settle
    applyStimulus(15, 2, 1'b0);
    applyStimulus(15, 0, 1'b0);

    // Request while busy: 2->4 with H=10 while sel=7 is held through the switch
    applyStimulus(2, 0, 1'b0);
    applyStimulus(4, 10, 1'b1);
    tick();
    checkOutput("spamIdleSel", 32'(out_sel), 32'd4);
    checkOutput("spamIdleBusy", 32'(busy), 32'd0);
    checkOutput("spamIdleDone", 32'(done), 32'd0);

    // Reset 3 cycles into an H=8 switch 4->6
    sel = 6'd6; hold_cycles = 8'd8; sel_update = 1'b1;
    tick();
    sel_update = 1'b0;
    checkOutput("preRstBusy", 32'(busy), 32'd1);
    tick(); tick(); tick();
    #3 rstn = 1'b0;
    #1;
    checkOutput("midRstOut", 32'(out), 32'd0);
    checkOutput("midRstSel", 32'(out_sel), 32'd0);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #4 rstn = 1'b1;
    expSel = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checkOutput("postRstDone", 32'(done), 32'd0);
      checkOutput("postRstSel", 32'(out_sel), 32'd0);
    end
    checkOutput("postRstOut", 32'(out), 32'h1234);
    checkOutput("postRstBusy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
